activity_monitor: RTL and testbench
===================================

ACTIVITY_MONITOR -- requirements
Module: activity_monitor

Interface
REQ-001 Parameter DEBOUNCE, default 4, is the number of consecutive cycles any_in must hold a level before that level is accepted; legal range is 2..255.
REQ-002 Parameter CNT_W, default 16, is the width of the event counter.
REQ-003 Port clk, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-005 Port any_in, input, 1 bit, is the OR-reduced user_in activity flag from the preceding combinational stage; it is treated as level data with no synchronizer inside this block.
REQ-006 Port clear, input, 1 bit, is a synchronous clear for the event counter.
REQ-007 Port active, output, 1 bit, is the debounced activity level.
REQ-008 Port evt_pulse, output, 1 bit, is a one-cycle strobe that fires on each accepted rising edge.
REQ-009 Port evt_count, output, CNT_W bits, is the counter snapshot.
REQ-010 Port cnt_valid, output, 1 bit, means the snapshot is valid.
REQ-011 Port cnt_ready, input, 1 bit, means the consumer accepts the snapshot.

Function
REQ-012 The FSM shall have exactly four states: IDLE, QUAL_HI, ACTIVE and QUAL_LO; active is 1 only in ACTIVE and QUAL_LO.
REQ-013 IDLE: any_in=1 -> QUAL_HI with the qualification count set to 1; otherwise stay in IDLE.
REQ-014 QUAL_HI: any_in=0 -> IDLE; any_in=1 with qualification count = DEBOUNCE-1 -> ACTIVE; otherwise increment the count.
REQ-015 ACTIVE: any_in=0 -> QUAL_LO with the count set to 1; otherwise stay in ACTIVE.
REQ-016 QUAL_LO: any_in=1 -> ACTIVE with no new event; any_in=0 with count = DEBOUNCE-1 -> IDLE; otherwise increment the count.
REQ-017 Latency: if any_in is sampled high on edges k through k+DEBOUNCE-1, then active and evt_pulse shall be high in the cycle after edge k+DEBOUNCE-1; evt_pulse shall be high for exactly that one cycle.
REQ-018 Each evt_pulse shall increment the internal counter by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-019 clear shall zero the internal counter on the next edge and has priority over a simultaneous increment; in that case evt_pulse still fires but the event is not counted.
REQ-020 When the counter changes and cnt_valid=0, the next cycle shall load evt_count with the new value and assert cnt_valid.
REQ-021 evt_count shall be held stable while cnt_valid=1.
REQ-022 cnt_valid=1 with cnt_ready=1 completes a transfer, and cnt_valid shall deassert on the next edge.
REQ-023 A change to the counter during a hold, or in the same cycle as a transfer, shall be recorded as pending; the cycle after the transfer shall reload the snapshot and reassert cnt_valid.
REQ-024 cnt_ready while cnt_valid=0 shall have no effect.
REQ-025 Counter changes caused by clear shall also raise cnt_valid, so the consumer observes 0.

Reset
REQ-026 reset shall force the FSM to IDLE and zero the qualification count, internal counter, pending flag, evt_count, cnt_valid, active and evt_pulse, all on the next edge.
REQ-027 reset applied mid-qualification or mid-handshake shall discard the partial state; any_in already high when reset releases shall need a full DEBOUNCE cycles before an event is produced.

Configuration
REQ-028 With the macro ACTIVITY_MON_TSTAMP_EN defined, the block shall add a 32-bit free-running cycle counter (zeroed by reset, wrapping) and an output port evt_tstamp, 32 bits, giving the counter value on the evt_pulse cycle.
REQ-029 With ACTIVITY_MON_TSTAMP_EN defined, evt_tstamp shall be snapshotted and held together with evt_count under the same cnt_valid/cnt_ready rules.
REQ-030 Without ACTIVITY_MON_TSTAMP_EN, the evt_tstamp port and the cycle counter shall not exist, and all other behaviour shall be identical.

Structure
REQ-031 Package activity_mon_pkg shall hold the state enum (IDLE, QUAL_HI, ACTIVE, QUAL_LO), DEBOUNCE_DEF=4, CNT_W_DEF=16 and TSTAMP_W=32.
REQ-032 Sub-module activity_debounce shall contain the FSM and qualification counter (REQ-012 to REQ-017) and output active and evt_pulse; the top level shall contain the counter, the snapshot handshake and the timestamp.

Verification
REQ-033 Scenario 1: DEBOUNCE=4, any_in high for 3 cycles then low -> no evt_pulse, active stays 0, cnt_valid stays 0.
REQ-034 Scenario 2: any_in high for 10 cycles starting at edge 0 -> evt_pulse exactly once, in the cycle after edge 3; cnt_valid=1 with evt_count=1 one cycle later.
REQ-035 Scenario 3: while ACTIVE, any_in low for 2 cycles then high -> active stays 1 and there is no second pulse; a low period of 4 cycles -> active=0 after the 4th low edge.
REQ-036 Scenario 4: hold cnt_ready=0 through 3 qualified events -> evt_count stays 1; then pulse cnt_ready -> cnt_valid drops for one cycle, then reasserts with evt_count=3.
REQ-037 Scenario 5: CNT_W=4, 17 events with cnt_ready=1 -> evt_count saturates at 15; clear in the same cycle as evt_pulse -> next snapshot is 0.
REQ-038 Scenario 6: with ACTIVITY_MON_TSTAMP_EN defined, an event pulse at cycle 37 after reset release -> evt_tstamp=37 is held with its evt_count until the transfer completes.

Source files
------------

// File: rtl/activity_mon_pkg.sv
// rtl/activity_mon_pkg.sv - shared types and defaults for the activity monitor
package activity_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL_HI = 2'd1,
        ACTIVE  = 2'd2,
        QUAL_LO = 2'd3
    } state_t;

    localparam int DEBOUNCE_DEF = 4;
    localparam int CNT_W_DEF    = 16;
    localparam int TSTAMP_W     = 32;

endpackage

// File: rtl/activity_debounce.sv
// rtl/activity_debounce.sv - four-state debounce FSM producing active level and event strobe
module activity_debounce
    import activity_mon_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic any_in,
    output logic active,
    output logic evt_pulse
);

    // Count value reached on the last qualifying sample before the level is accepted
    localparam logic [7:0] QUAL_LAST = 8'(DEBOUNCE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] qcnt;
    logic [7:0] qcnt_nxt;
    logic       active_nxt;
    logic       pulse_nxt;

    // State, qualification count and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            qcnt      <= 8'd0;
            active    <= 1'b0;
            evt_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            qcnt      <= qcnt_nxt;
            active    <= active_nxt;
            evt_pulse <= pulse_nxt;
        end
    end

    // Next-state decode; the strobe is raised only on the QUAL_HI -> ACTIVE transition
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (any_in) begin
                    state_nxt = QUAL_HI;
                    qcnt_nxt  = 8'd1;
                end
            end
            QUAL_HI: begin
                if (!any_in) begin
                    state_nxt = IDLE;
                    qcnt_nxt  = 8'd0;
                end else if (qcnt == QUAL_LAST) begin
                    state_nxt = ACTIVE;
                    qcnt_nxt  = 8'd0;
                    pulse_nxt = 1'b1;
                end else begin
                    qcnt_nxt  = qcnt + 8'd1;
                end
            end
            ACTIVE: begin
                if (!any_in) begin
                    state_nxt = QUAL_LO;
                    qcnt_nxt  = 8'd1;
                end
            end
            QUAL_LO: begin
                if (any_in) begin
                    state_nxt = ACTIVE;
                    qcnt_nxt  = 8'd0;
                end else if (qcnt == QUAL_LAST) begin
                    state_nxt = IDLE;
                    qcnt_nxt  = 8'd0;
                end else begin
                    qcnt_nxt  = qcnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                qcnt_nxt  = 8'd0;
            end
        endcase
        active_nxt = (state_nxt == ACTIVE) || (state_nxt == QUAL_LO);
    end

endmodule

// File: rtl/activity_monitor.sv
// rtl/activity_monitor.sv - debounced activity monitor with event counter snapshot; ACTIVITY_MON_TSTAMP_EN adds evt_tstamp
module activity_monitor
    import activity_mon_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             any_in,
    input  logic             clear,
    output logic             active,
    output logic             evt_pulse,
    output logic [CNT_W-1:0] evt_count,
    output logic             cnt_valid,
    input  logic             cnt_ready
`ifdef ACTIVITY_MON_TSTAMP_EN
    ,
    output logic [TSTAMP_W-1:0] evt_tstamp
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             changed;
    logic             pending;
    logic             snap_load;
    logic             xfer;

    activity_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .any_in    (any_in),
        .active    (active),
        .evt_pulse (evt_pulse)
    );

    // Counter update: clear wins over an increment, saturated increments are not a change
    always_comb begin
        changed = clear || (evt_pulse && (cnt != CNT_MAX));
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = '0;
        end else if (changed) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        snap_load = !cnt_valid && (changed || pending);
        xfer      = cnt_valid && cnt_ready;
    end

    // Internal event counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Snapshot handshake: load when idle, hold while valid, remember changes seen during a hold
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_count <= '0;
            cnt_valid <= 1'b0;
            pending   <= 1'b0;
        end else if (snap_load) begin
            evt_count <= cnt_nxt;
            cnt_valid <= 1'b1;
            pending   <= 1'b0;
        end else if (xfer) begin
            cnt_valid <= 1'b0;
            if (changed) begin
                pending <= 1'b1;
            end
        end else if (changed) begin
            pending <= 1'b1;
        end
    end

`ifdef ACTIVITY_MON_TSTAMP_EN
    logic [TSTAMP_W-1:0] cyc_cnt;
    logic [TSTAMP_W-1:0] last_ts;
    logic [TSTAMP_W-1:0] ts_nxt;

    // Timestamp of the most recent event, including one firing in the current cycle
    always_comb begin
        ts_nxt = evt_pulse ? cyc_cnt : last_ts;
    end

    // Free-running cycle counter, latest event time and the held timestamp snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt    <= '0;
            last_ts    <= '0;
            evt_tstamp <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + TSTAMP_W'(1);
            last_ts <= ts_nxt;
            if (snap_load) begin
                evt_tstamp <= ts_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_activity_monitor.sv
// tb/tb_activity_monitor.sv - directed self-checking bench for activity_monitor
module tb_activity_monitor;

    logic        clk;
    logic        reset;
    logic        any_in;
    logic        clear;
    logic        active;
    logic        evt_pulse;
    logic [3:0]  evt_count;
    logic        cnt_valid;
    logic        cnt_ready;
`ifdef ACTIVITY_MON_TSTAMP_EN
    logic [31:0] evt_tstamp;
`endif

    int tests;
    int fails;
    int pulses;
    int p0;

    activity_monitor #(
        .DEBOUNCE (4),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .any_in    (any_in),
        .clear     (clear),
        .active    (active),
        .evt_pulse (evt_pulse),
        .evt_count (evt_count),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready)
`ifdef ACTIVITY_MON_TSTAMP_EN
        ,
        .evt_tstamp(evt_tstamp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles away from the active edge
    always @(negedge clk) begin
        if (evt_pulse) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_event();
        any_in = 1'b1;
        repeat (4) tick();
        any_in = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pulses = 0;
        reset = 1'b1;
        any_in = 1'b0;
        clear = 1'b0;
        cnt_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_active", 32'(active), 32'd0);
        check("rst_pulse", 32'(evt_pulse), 32'd0);
        check("rst_valid", 32'(cnt_valid), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);

        // Scenario 1: three-cycle glitch is rejected
        p0 = pulses;
        any_in = 1'b1;
        repeat (3) tick();
        check("s1_active_hi", 32'(active), 32'd0);
        any_in = 1'b0;
        repeat (6) tick();
        check("s1_pulses", 32'(pulses - p0), 32'd0);
        check("s1_active", 32'(active), 32'd0);
        check("s1_valid", 32'(cnt_valid), 32'd0);

        // Scenario 2: ten-cycle high produces one pulse after edge 3
        p0 = pulses;
        any_in = 1'b1;
        tick();
        check("s2_e0_pulse", 32'(evt_pulse), 32'd0);
        repeat (2) tick();
        check("s2_e2_active", 32'(active), 32'd0);
        tick();
        check("s2_e3_pulse", 32'(evt_pulse), 32'd1);
        check("s2_e3_active", 32'(active), 32'd1);
        tick();
        check("s2_e4_pulse", 32'(evt_pulse), 32'd0);
        check("s2_e4_valid", 32'(cnt_valid), 32'd1);
        check("s2_e4_count", 32'(evt_count), 32'd1);
        repeat (5) tick();
        any_in = 1'b0;
        check("s2_once", 32'(pulses - p0), 32'd1);
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        check("s2_xfer_valid", 32'(cnt_valid), 32'd0);

        // Scenario 3: short low gap is bridged, four lows drop active
        tick();
        check("s3_gap_active", 32'(active), 32'd1);
        any_in = 1'b1;
        tick();
        check("s3_back_active", 32'(active), 32'd1);
        repeat (3) tick();
        check("s3_no_second", 32'(pulses - p0), 32'd1);
        any_in = 1'b0;
        repeat (3) tick();
        check("s3_lo3_active", 32'(active), 32'd1);
        tick();
        check("s3_lo4_active", 32'(active), 32'd0);

        // Scenario 4: clear is observed, then three events held behind a stalled consumer
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s4_clr_valid", 32'(cnt_valid), 32'd1);
        check("s4_clr_count", 32'(evt_count), 32'd0);
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        check("s4_clr_xfer", 32'(cnt_valid), 32'd0);
        repeat (3) do_event();
        check("s4_hold_count", 32'(evt_count), 32'd1);
        check("s4_hold_valid", 32'(cnt_valid), 32'd1);
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        check("s4_drop_valid", 32'(cnt_valid), 32'd0);
        tick();
        check("s4_reload_valid", 32'(cnt_valid), 32'd1);
        check("s4_reload_count", 32'(evt_count), 32'd3);

        // Scenario 5: saturation at 15, then clear coinciding with a pulse
        cnt_ready = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (17) do_event();
        repeat (3) tick();
        check("s5_sat_count", 32'(evt_count), 32'd15);
        any_in = 1'b1;
        repeat (4) tick();
        check("s5_pulse", 32'(evt_pulse), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        any_in = 1'b0;
        repeat (4) tick();
        check("s5_clr_count", 32'(evt_count), 32'd0);
        do_event();
        repeat (2) tick();
        check("s5_after_count", 32'(evt_count), 32'd1);

        // Reset mid-qualification and mid-handshake discards partial state
        cnt_ready = 1'b0;
        do_event();
        any_in = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("r_valid", 32'(cnt_valid), 32'd0);
        check("r_count", 32'(evt_count), 32'd0);
        check("r_active", 32'(active), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("r_q3_active", 32'(active), 32'd0);
        tick();
        check("r_q4_active", 32'(active), 32'd1);
        check("r_q4_pulse", 32'(evt_pulse), 32'd1);
        any_in = 1'b0;
        repeat (4) tick();

        // Scenario 6: event after edge 37 from reset release, held until transfer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (33) tick();
        any_in = 1'b1;
        repeat (4) tick();
        check("s6_pulse", 32'(evt_pulse), 32'd1);
        tick();
        any_in = 1'b0;
        check("s6_valid", 32'(cnt_valid), 32'd1);
        check("s6_count", 32'(evt_count), 32'd1);
`ifdef ACTIVITY_MON_TSTAMP_EN
        check("s6_tstamp", evt_tstamp, 32'd37);
`endif
        repeat (5) tick();
        check("s6_hold_count", 32'(evt_count), 32'd1);
`ifdef ACTIVITY_MON_TSTAMP_EN
        check("s6_hold_tstamp", evt_tstamp, 32'd37);
`endif
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        check("s6_xfer_valid", 32'(cnt_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
